// File: rtl/grid_stream_packer_pkg.sv
// grid_stream_packer_pkg: shared constants, FSM state type and write-record type for the grid loader
//   ASCII_LF / ASCII_CR : line-feed and carriage-return codes
//   packer_state_e      : packer FSM states
//   grid_wr_t           : one chunk write {bank,row,col,vec}, fields sized for the largest supported build
package grid_stream_packer_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } packer_state_e;

    typedef struct packed {
        logic [7:0]  bank;
        logic [15:0] row;
        logic [15:0] col;
        logic [63:0] vec;
    } grid_wr_t;

endpackage

// File: rtl/grid_stream_packer_bank_map.sv
// grid_stream_packer_bank_map: tracks bank = row % NUM_BANKS and bank_row = row / NUM_BANKS without a divider
//   clock_i, reset_i : clock, async active-high reset
//   clr_i            : return to row 0
//   inc_i            : advance to the next row
//   bank_o           : bank of the current row
//   bank_row_o       : bank-local row of the current row
module grid_stream_packer_bank_map #(
    parameter int NUM_BANKS = 3,
    parameter int BW        = 2,
    parameter int BRW       = 6
) (
    input  logic           clock_i,
    input  logic           reset_i,
    input  logic           clr_i,
    input  logic           inc_i,
    output logic [BW-1:0]  bank_o,
    output logic [BRW-1:0] bank_row_o
);

    logic [BW-1:0]  bank_q, bank_d;
    logic [BRW-1:0] brow_q, brow_d;
    logic           wrap;

    assign wrap = bank_q == BW'(NUM_BANKS - 1);

    always_comb begin
        bank_d = clr_i ? '0 : inc_i ? (wrap ? '0 : bank_q + 1'b1) : bank_q;
        brow_d = clr_i ? '0 : (inc_i && wrap) ? brow_q + 1'b1 : brow_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bank_q <= '0;
            brow_q <= '0;
        end else begin
            bank_q <= bank_d;
            brow_q <= brow_d;
        end
    end

    assign bank_o     = bank_q;
    assign bank_row_o = brow_q;

endmodule

// File: rtl/grid_stream_packer.sv
// grid_stream_packer: packs an ASCII grid stream into TX_W-bit row chunks written to row-interleaved banks
//   clock_i, reset_i     : clock, async active-high reset
//   start_i              : clear counters/flags and arm (ignored while writing)
//   byte_valid_i/data/last, byte_ready_o : byte stream, consumed on valid && ready
//   wr_req_o, wr_bank_o, wr_row_o, wr_col_o, wr_vec_o, wr_ack_i : chunk write handshake
//   mem_busy_i           : holds off a new request while high
//   done_o, overflow_o   : sticky completion / overflow flags
//   rows_out_o           : non-empty rows written
//   cells_set_o          : saturating count of accepted MATCH_CHAR bytes
module grid_stream_packer
    import grid_stream_packer_pkg::*;
#(
    parameter int          TX_W       = 32,
    parameter int          MAX_COLS   = 140,
    parameter int          MAX_ROWS   = 140,
    parameter int          NUM_BANKS  = 3,
    parameter logic [7:0]  MATCH_CHAR = 8'h40,
    localparam int BW   = $clog2(NUM_BANKS),
    localparam int BRW  = $clog2(MAX_ROWS / NUM_BANKS + 1),
    localparam int COLW = $clog2(MAX_COLS),
    localparam int RW   = $clog2(MAX_ROWS + 1),
    localparam int CSW  = $clog2(MAX_ROWS * MAX_COLS + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    output logic             wr_req_o,
    output logic [BW-1:0]    wr_bank_o,
    output logic [BRW-1:0]   wr_row_o,
    output logic [COLW-1:0]  wr_col_o,
    output logic [TX_W-1:0]  wr_vec_o,
    input  logic             wr_ack_i,
    input  logic             mem_busy_i,
    output logic             done_o,
    output logic             overflow_o,
    output logic [RW-1:0]    rows_out_o,
    output logic [CSW-1:0]   cells_set_o
);

    // TX_W is a power of two, so chunk arithmetic reduces to bit slices of the column
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int LW = $clog2(TX_W);

    packer_state_e    state_q, state_d;
    logic [TX_W-1:0]  acc_q, acc_d, vec_q, vec_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d, rows_q, rows_d;
    logic [COLW-1:0]  wcol_q, wcol_d;
    logic [CSW-1:0]   cells_q, cells_d;
    logic             req_q, req_d, final_q, final_d, pend_q, pend_d, eol_q, eol_d;
    logic             done_q, done_d, ovf_q, ovf_d;
    logic             is_lf, is_cr, is_data, is_match, boundary, take, clear;
    logic [LW-1:0]    idx;

    function automatic logic [COLW-1:0] chunk_base(input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = c - 1'b1;
        return COLW'({m[CW-1:LW], {LW{1'b0}}});
    endfunction

    assign is_lf    = byte_data_i == ASCII_LF;
    assign is_cr    = byte_data_i == ASCII_CR;
    assign is_data  = !is_lf && !is_cr;
    assign is_match = byte_data_i == MATCH_CHAR;
    assign idx      = col_q[LW-1:0];
    assign boundary = idx == '0 && col_q != '0;
    assign take     = state_q == ST_WRITE && req_q && wr_ack_i;
    assign clear    = start_i && state_q != ST_WRITE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        vec_d   = vec_q;
        col_d   = col_q;
        row_d   = row_q;
        rows_d  = rows_q;
        wcol_d  = wcol_q;
        cells_d = cells_q;
        req_d   = req_q;
        final_d = final_q;
        pend_d  = pend_q;
        eol_d   = eol_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_ACCEPT;
            acc_d   = '0;
            col_d   = '0;
            row_d   = '0;
            rows_d  = '0;
            cells_d = '0;
            req_d   = 1'b0;
            final_d = 1'b0;
            pend_d  = 1'b0;
            eol_d   = 1'b0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_ACCEPT && byte_valid_i) begin
            if (is_data && (col_q >= CW'(MAX_COLS) || row_q >= RW'(MAX_ROWS))) begin
                ovf_d = 1'b1;
            end else if (is_data) begin
                cells_d = (is_match && cells_q != '1) ? cells_q + 1'b1 : cells_q;
                col_d   = col_q + 1'b1;
                if (boundary) begin
                    // full chunk leaves; this char opens the next chunk at bit 0
                    vec_d   = acc_q;
                    wcol_d  = COLW'(col_q - CW'(TX_W));
                    acc_d   = TX_W'(is_match);
                    eol_d   = 1'b0;
                    final_d = 1'b0;
                    pend_d  = byte_last_i;
                    state_d = ST_WRITE;
                end else begin
                    acc_d[idx] = is_match;
                end
            end else if (is_lf && col_q != '0) begin
                vec_d   = acc_q;
                wcol_d  = chunk_base(col_q);
                acc_d   = '0;
                eol_d   = 1'b1;
                final_d = byte_last_i;
                pend_d  = 1'b0;
                state_d = ST_WRITE;
            end
            // last byte: flush whatever the char rule left behind, else finish
            if (byte_last_i && state_d != ST_WRITE) begin
                if (col_d != '0) begin
                    vec_d   = acc_d;
                    wcol_d  = chunk_base(col_d);
                    acc_d   = '0;
                    eol_d   = 1'b1;
                    final_d = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
        end else if (take) begin
            req_d = 1'b0;
            if (pend_q) begin
                // residual chunk after a boundary char that was also the last byte
                vec_d   = acc_q;
                wcol_d  = chunk_base(col_q);
                acc_d   = '0;
                eol_d   = 1'b1;
                final_d = 1'b1;
                pend_d  = 1'b0;
            end else begin
                state_d = final_q ? ST_DONE : ST_ACCEPT;
                done_d  = final_q;
                col_d   = eol_q ? '0 : col_q;
                row_d   = eol_q ? row_q + 1'b1 : row_q;
                rows_d  = eol_q ? rows_q + 1'b1 : rows_q;
            end
        end else if (state_q == ST_WRITE && !req_q && !mem_busy_i) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            vec_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rows_q  <= '0;
            wcol_q  <= '0;
            cells_q <= '0;
            req_q   <= 1'b0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            vec_q   <= vec_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            wcol_q  <= wcol_d;
            cells_q <= cells_d;
            req_q   <= req_d;
            final_q <= final_d;
            pend_q  <= pend_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    grid_stream_packer_bank_map #(
        .NUM_BANKS (NUM_BANKS),
        .BW        (BW),
        .BRW       (BRW)
    ) u_bank_map (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clr_i      (clear),
        .inc_i      (take && eol_q),
        .bank_o     (wr_bank_o),
        .bank_row_o (wr_row_o)
    );

    assign byte_ready_o = state_q == ST_ACCEPT;
    assign wr_req_o     = req_q;
    assign wr_col_o     = wcol_q;
    assign wr_vec_o     = vec_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign rows_out_o   = rows_q;
    assign cells_set_o  = cells_q;

endmodule

// File: tb/tb_grid_stream_packer.sv
// tb_grid_stream_packer: directed scoreboard bench for grid_stream_packer (TX_W=4, 10 cols, 8 rows, 3 banks)
module tb_grid_stream_packer;
    import grid_stream_packer_pkg::*;

    localparam int TX_W = 4, MAX_COLS = 10, MAX_ROWS = 8, NUM_BANKS = 3;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       bv = 1'b0, bl = 1'b0, ack = 1'b0, busy = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       byte_ready, wr_req, done, overflow;
    logic [1:0] wr_bank, wr_row;
    logic [3:0] wr_col, wr_vec, rows_out;
    logic [6:0] cells_set;

    int       errors = 0, checks = 0, ack_delay = 0;
    grid_wr_t sb[$];

    grid_stream_packer #(
        .TX_W (TX_W), .MAX_COLS (MAX_COLS), .MAX_ROWS (MAX_ROWS),
        .NUM_BANKS (NUM_BANKS), .MATCH_CHAR (8'h40)
    ) dut (
        .clock_i (clk), .reset_i (rst), .start_i (start),
        .byte_valid_i (bv), .byte_data_i (bd), .byte_last_i (bl), .byte_ready_o (byte_ready),
        .wr_req_o (wr_req), .wr_bank_o (wr_bank), .wr_row_o (wr_row), .wr_col_o (wr_col),
        .wr_vec_o (wr_vec), .wr_ack_i (ack), .mem_busy_i (busy),
        .done_o (done), .overflow_o (overflow), .rows_out_o (rows_out), .cells_set_o (cells_set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_wr(input int b, input int r, input int c, input logic [3:0] v);
        grid_wr_t e;
        e.bank = 8'(b);
        e.row  = 16'(r);
        e.col  = 16'(c);
        e.vec  = 64'(v);
        sb.push_back(e);
    endtask

    // memory model: acks each request after ack_delay waiting cycles, checks payload against the scoreboard
    task automatic responder();
        int       wcnt = 0;
        logic     held_v = 1'b0;
        grid_wr_t held, obs, e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ack = 1'b0;
                wcnt = 0;
                held_v = 1'b0;
            end else if (ack) begin
                ack = 1'b0;
            end else if (wr_req) begin
                obs.bank = 8'(wr_bank);
                obs.row  = 16'(wr_row);
                obs.col  = 16'(wr_col);
                obs.vec  = 64'(wr_vec);
                if (held_v) chk("payload_stable", obs, held);
                held = obs;
                held_v = 1'b1;
                chk("ready_low_in_write", 64'(byte_ready), 64'd0);
                if (wcnt >= ack_delay) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_write: got b%0d r%0d c%0d v%0h expected none", obs.bank, obs.row, obs.col, obs.vec);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        checks++;
                        assert (obs === e) else begin
                            errors++;
                            $error("FAIL write: got b%0d r%0d c%0d v%0h expected b%0d r%0d c%0d v%0h",
                                   obs.bank, obs.row, obs.col, obs.vec, e.bank, e.row, e.col, e.vec);
                        end
                    end
                    ack = 1'b1;
                    wcnt = 0;
                    held_v = 1'b0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                held_v = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int t = 0;
        bv = 1'b1;
        bd = c;
        bl = last;
        while (!byte_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("byte_accept_timeout", 64'(t), 64'd0);
        @(negedge clk);
        bv = 1'b0;
        bl = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) send(s[i], last && i == s.len() - 1);
    endtask

    task automatic drain();
        int t = 0;
        while (!(sb.size() == 0 && (byte_ready || done)) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t >= 500), 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        fork responder(); join_none
        repeat (2) @(negedge clk);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rows_out", 64'(rows_out), 64'd0);
        chk("rst_cells_set", 64'(cells_set), 64'd0);
        chk("rst_wr_vec", 64'(wr_vec), 64'd0);
        chk("rst_ready", 64'(byte_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_not_ready", 64'(byte_ready), 64'd0);

        // single row split across two chunks
        do_start();
        chk("armed_ready", 64'(byte_ready), 64'd1);
        expect_wr(0, 0, 0, 4'b1101);
        expect_wr(0, 0, 4, 4'b0001);
        send_str("@.@@@\n", 1'b0);
        drain();
        chk("t1_rows_out", 64'(rows_out), 64'd1);
        chk("t1_cells_set", 64'(cells_set), 64'd4);
        chk("t1_done", 64'(done), 64'd0);

        // bank interleaving
        do_start();
        chk("t2_rows_cleared", 64'(rows_out), 64'd0);
        chk("t2_cells_cleared", 64'(cells_set), 64'd0);
        expect_wr(0, 0, 0, 4'b0011);
        expect_wr(1, 0, 0, 4'b0011);
        expect_wr(2, 0, 0, 4'b0011);
        expect_wr(0, 1, 0, 4'b0011);
        for (int r = 0; r < 4; r++) send_str("@@\n", 1'b0);
        drain();
        chk("t2_rows_out", 64'(rows_out), 64'd4);
        chk("t2_cells_set", 64'(cells_set), 64'd8);

        // CR ignored, blank line skipped, last byte flushes
        do_start();
        expect_wr(0, 0, 0, 4'b0011);
        expect_wr(1, 0, 0, 4'b0001);
        send_str("@@", 1'b0);
        send(8'h0D, 1'b0);
        send_str("\n\n", 1'b0);
        send(8'h40, 1'b1);
        drain();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_rows_out", 64'(rows_out), 64'd2);
        chk("t3_cells_set", 64'(cells_set), 64'd3);
        chk("t3_no_overflow", 64'(overflow), 64'd0);
        chk("t3_done_not_ready", 64'(byte_ready), 64'd0);

        // mem_busy hold-off and slow ack
        do_start();
        busy = 1'b1;
        ack_delay = 10;
        expect_wr(0, 0, 0, 4'b0001);
        send_str("@.\n", 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_req_held_off", 64'(wr_req), 64'd0);
            chk("t4_ready_low", 64'(byte_ready), 64'd0);
            @(negedge clk);
        end
        busy = 1'b0;
        drain();
        ack_delay = 0;
        chk("t4_rows_out", 64'(rows_out), 64'd1);

        // column overflow: extra chars dropped, next row normal
        do_start();
        expect_wr(0, 0, 0, 4'b1111);
        expect_wr(0, 0, 4, 4'b1111);
        expect_wr(0, 0, 8, 4'b0011);
        expect_wr(1, 0, 0, 4'b0101);
        for (int i = 0; i < MAX_COLS + 3; i++) send(8'h40, 1'b0);
        chk("t5_overflow_set", 64'(overflow), 64'd1);
        send_str("\n@.@\n", 1'b0);
        drain();
        chk("t5_rows_out", 64'(rows_out), 64'd2);
        chk("t5_cells_set", 64'(cells_set), 64'd12);
        chk("t5_overflow_sticky", 64'(overflow), 64'd1);

        // reset while a request is pending, then a clean reload
        do_start();
        ack_delay = 50;
        expect_wr(0, 0, 0, 4'b0001);
        send_str("@\n", 1'b0);
        for (int t = 0; t < 20 && !wr_req; t++) @(negedge clk);
        chk("t6_req_raised", 64'(wr_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_req_dropped", 64'(wr_req), 64'd0);
        chk("t6_rows_cleared", 64'(rows_out), 64'd0);
        sb.delete();
        ack_delay = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        expect_wr(0, 0, 0, 4'b0001);
        expect_wr(1, 0, 0, 4'b1111);
        expect_wr(1, 0, 4, 4'b0001);
        send_str("@\n", 1'b0);
        send_str("@@@@@", 1'b1);
        drain();
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_rows_out", 64'(rows_out), 64'd2);
        chk("t6_cells_set", 64'(cells_set), 64'd6);

        // row overflow: a char beyond MAX_ROWS is dropped and the stream ends empty
        do_start();
        for (int r = 0; r < MAX_ROWS; r++) expect_wr(r % NUM_BANKS, r / NUM_BANKS, 0, 4'b0001);
        for (int r = 0; r < MAX_ROWS; r++) send_str("@\n", 1'b0);
        drain();
        chk("t7_no_overflow_yet", 64'(overflow), 64'd0);
        send(8'h40, 1'b1);
        repeat (2) @(negedge clk);
        chk("t7_overflow", 64'(overflow), 64'd1);
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_rows_out", 64'(rows_out), 64'd8);
        chk("t7_cells_set", 64'(cells_set), 64'd8);
        chk("t7_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("t7_no_req", 64'(wr_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
